rca_add_sequencer: RTL and testbench

Multi-cycle 64-bit add/subtract controller that time-shares one internal 32-bit ripple-carry adder over two passes, lower half then upper half. It sits in front of the arithmetic datapath and replaces a full-width 64-bit ripple chain when area matters more than throughput. It uses a valid/ready request-response handshake and sequences the passes with a small FSM. It registers the carry between passes and holds the result until the consumer takes it.

---
 rtl/rca_add_sequencer.sv | 143 ++++++++++++++
 tb/tb_rca_add_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_add_sequencer.sv
// rtl/rca_add_sequencer.sv - two-pass 64-bit add/subtract over one shared 32-bit ripple-carry adder (optional subtract: ADDSEQ_SUB_EN)
module rca_add_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
`ifdef ADDSEQ_SUB_EN
    input  logic        op,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] s,
    output logic        cout,
    output logic        ovf
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t      state;
    state_t      state_nxt;

    // operands captured on accept; b_r already holds the effective (possibly inverted) B
    logic [63:0] a_r;
    logic [63:0] b_r;
    logic        c_r;
    logic        mid_c;

    logic [63:0] s_r;
    logic        cout_r;
    logic        ovf_r;

    logic [63:0] b_eff;
    logic        c_eff;
    logic        accept;

    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic [32:0] carry;

`ifdef ADDSEQ_SUB_EN
    // subtract is A + ~B + 1, so the carry-in is forced and cin is ignored
    assign b_eff = op ? ~b : b;
    assign c_eff = op ? 1'b1 : cin;
`else
    assign b_eff = b;
    assign c_eff = cin;
`endif

    assign accept = in_valid && in_ready;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic: fixed LO/HI sequence, then wait for the consumer
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LO;
            LO:      state_nxt = HI;
            HI:      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // handshake outputs decoded from state; no overlap between result and new request
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // half select: upper operand half and mid-carry in HI, lower half and latched carry otherwise
    always_comb begin
        add_a   = a_r[31:0];
        add_b   = b_r[31:0];
        add_cin = c_r;
        if (state == HI) begin
            add_a   = a_r[63:32];
            add_b   = b_r[63:32];
            add_cin = mid_c;
        end
    end

    // the single shared 32-bit ripple-carry chain
    always_comb begin
        carry    = '0;
        add_sum  = '0;
        carry[0] = add_cin;
        for (int i = 0; i < 32; i++) begin
            add_sum[i]   = add_a[i] ^ add_b[i] ^ carry[i];
            carry[i + 1] = (add_a[i] & add_b[i]) | (add_a[i] & carry[i]) | (add_b[i] & carry[i]);
        end
    end

    // operand capture on accept and per-pass result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            c_r    <= 1'b0;
            mid_c  <= 1'b0;
            s_r    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            if (accept) begin
                a_r <= a;
                b_r <= b_eff;
                c_r <= c_eff;
            end
            if (state == LO) begin
                s_r[31:0] <= add_sum;
                mid_c     <= carry[32];
            end
            if (state == HI) begin
                s_r[63:32] <= add_sum;
                cout_r     <= carry[32];
                ovf_r      <= (a_r[63] == b_r[63]) && (add_sum[31] != a_r[63]);
            end
        end
    end

    assign s    = s_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_rca_add_sequencer.sv
// tb/tb_rca_add_sequencer.sv - scoreboard bench for rca_add_sequencer (subtract cases need ADDSEQ_SUB_EN)
module tb_rca_add_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] s;
    logic        cout;
    logic        ovf;

    typedef struct packed {
        logic [63:0] s;
        logic        cout;
        logic        ovf;
    } res_t;

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    rca_add_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADDSEQ_SUB_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference: straight 65-bit arithmetic, no notion of passes
    function automatic res_t model(input logic [63:0] ma, input logic [63:0] mb, input logic mcin, input logic mop);
        logic [63:0] be;
        logic        ce;
        logic [64:0] t;
        res_t        r;
        be     = mop ? ~mb : mb;
        ce     = mop ? 1'b1 : mcin;
        t      = {1'b0, ma} + {1'b0, be} + {64'd0, ce};
        r.s    = t[63:0];
        r.cout = t[64];
        r.ovf  = (ma[63] == be[63]) && (t[63] != ma[63]);
        return r;
    endfunction

    // drive one request from a negedge; returns at the negedge after the accept edge
    task automatic send(input logic [63:0] ta, input logic [63:0] tb_v, input logic tc, input logic top, output bit ok);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok       = in_ready;
        a        = ta;
        b        = tb_v;
        cin      = tc;
        op       = top;
        in_valid = 1'b1;
        @(posedge clk);
        acc_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        cin      = ~tc;
        op       = ~top;
    endtask

    // count negedges since the accept edge until out_valid, bounded; -1 on timeout
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; op = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (s !== 64'd0) begin n_bad++; $display("FAIL reset_s: got %h want 0", s); end
        n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL reset_cout: got %b want 0", cout); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_vector(input string name, input logic [63:0] ta, input logic [63:0] tb_v, input logic tc, input logic top);
        bit   ok;
        int   lat;
        res_t e;
        exp_q.push_back(model(ta, tb_v, tc, top));
        send(ta, tb_v, tc, top, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_accept: in_ready never rose", name); end
        wait_valid(lat);
        n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL %s_latency: got %0d want 3", name, lat); end
        e = exp_q.pop_front();
        n_cmp++; if (s !== e.s) begin n_bad++; $display("FAIL %s_s: got %h want %h", name, s, e.s); end
        n_cmp++; if (cout !== e.cout) begin n_bad++; $display("FAIL %s_cout: got %b want %b", name, cout, e.cout); end
        n_cmp++; if (ovf !== e.ovf) begin n_bad++; $display("FAIL %s_ovf: got %b want %b", name, ovf, e.ovf); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL %s_drain: out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        bit   ok;
        int   lat;
        res_t e;
        exp_q.push_back(model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0));
        send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, ok);
        wait_valid(lat);
        n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL bp_latency: got %0d want 3", lat); end
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1 || s !== e.s || cout !== e.cout || ovf !== e.ovf) begin
                n_bad++; $display("FAIL bp_hold%0d: valid=%b s=%h cout=%b ovf=%b want 1 %h %b %b", i, out_valid, s, cout, ovf, e.s, e.cout, e.ovf);
            end
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready%0d: got %b want 0", i, in_ready); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        ok = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        n_cmp++; if (ok) begin n_bad++; $display("FAIL bp_ignored_request: out_valid rose, want 0"); end
    endtask

    task automatic test_abort();
        bit ok;
        bit seen = 1'b0;
        send(64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0001_0000, 1'b1, 1'b0, ok);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL abort_state: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        n_cmp++; if (s !== 64'd0 || cout !== 1'b0 || ovf !== 1'b0) begin
            n_bad++; $display("FAIL abort_result: s=%h cout=%b ovf=%b want 0", s, cout, ovf);
        end
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_cmp++; if (seen) begin n_bad++; $display("FAIL abort_out_valid: got 1 want 0"); end
    endtask

    task automatic test_back_to_back();
        bit          ok;
        int          lat;
        int          prev = 0;
        res_t        e;
        logic [63:0] ra, rb;
        logic        rc, ro;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom);
`ifdef ADDSEQ_SUB_EN
            ro = 1'($urandom);
`else
            ro = 1'b0;
`endif
            exp_q.push_back(model(ra, rb, rc, ro));
            send(ra, rb, rc, ro, ok);
            if (i > 0) begin
                n_cmp++; if (acc_cyc - prev != 4) begin n_bad++; $display("FAIL b2b_spacing%0d: got %0d want 4", i, acc_cyc - prev); end
            end
            prev = acc_cyc;
            wait_valid(lat);
            e = exp_q.pop_front();
            n_cmp++; if (lat != 3 || s !== e.s || cout !== e.cout || ovf !== e.ovf) begin
                n_bad++; $display("FAIL b2b_result%0d: lat=%0d s=%h cout=%b ovf=%b want 3 %h %b %b", i, lat, s, cout, ovf, e.s, e.cout, e.ovf);
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_vector("cross_carry", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        test_vector("full_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
        test_vector("signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        test_vector("neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
`ifdef ADDSEQ_SUB_EN
        test_vector("subtract", 64'd5, 64'd7, 1'b0, 1'b1);
        test_vector("sub_no_borrow", 64'd7, 64'd5, 1'b0, 1'b1);
`endif
        test_backpressure();
        test_abort();
        test_vector("after_abort", 64'h0000_0001_FFFF_FFFF, 64'h0000_0001_0000_0001, 1'b1, 1'b0);
        test_back_to_back();
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
